// File: rtl/z80fi_insn_recorder.sv
// z80fi_insn_recorder: captures one Z80 instruction's pre/post core state
// and its data-bus transactions, and publishes them as a single record.
//
// Ports:
//   clk, reset (sync, active-low)
//   insn_start, insn_done        instruction boundary pulses
//   regs_live[209:0]             packed live core state
//   mem_rd_stb, mem_wr_stb,
//   io_rd_stb, io_wr_stb         bus-transaction strobes
//   bus_fetch                    marks mem_rd_stb as opcode/operand fetch
//   bus_addr[15:0], bus_data[7:0]
//   z80fi_valid                  one-cycle publish pulse
//   z80fi_regs_in/out[209:0]     pre/post instruction state
//   mem_rd, mem_rd2, mem_wr, mem_wr2, io_rd, io_wr   record flags
//   bus_raddr, bus_raddr2, bus_waddr, bus_waddr2, bus_wdata, bus_wdata2
//   overflow                     record dropped a transaction
//   insn_count[CNT_W-1:0]        published-record counter
module z80fi_insn_recorder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             insn_start,
   input  logic             insn_done,
   input  logic [209:0]     regs_live,
   input  logic             mem_rd_stb,
   input  logic             mem_wr_stb,
   input  logic             io_rd_stb,
   input  logic             io_wr_stb,
   input  logic             bus_fetch,
   input  logic [15:0]      bus_addr,
   input  logic [7:0]       bus_data,
   output logic             z80fi_valid,
   output logic [209:0]     z80fi_regs_in,
   output logic [209:0]     z80fi_regs_out,
   output logic             mem_rd,
   output logic             mem_rd2,
   output logic             mem_wr,
   output logic             mem_wr2,
   output logic             io_rd,
   output logic             io_wr,
   output logic [15:0]      bus_raddr,
   output logic [15:0]      bus_raddr2,
   output logic [15:0]      bus_waddr,
   output logic [15:0]      bus_waddr2,
   output logic [7:0]       bus_wdata,
   output logic [7:0]       bus_wdata2,
   output logic             overflow,
   output logic [CNT_W-1:0] insn_count
);

   localparam int unsigned REGS_W = 210;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {IDLE, OPEN, CAPTURE} state_t;

   state_t state, state_d;
   logic   load_pre, clear_slots, apply_stb, publish;

   // working record
   logic [REGS_W-1:0] pre_q;
   logic              rd1_v, rd1_io, rd2_v, wr1_v, wr1_io, wr2_v, ovf_q;
   logic [ADDR_W-1:0] raddr1_q, raddr2_q, waddr1_q, waddr2_q;
   logic [DATA_W-1:0] wdata1_q, wdata2_q;

   // any two strobes in one cycle (fetch reads included) poison the cycle
   logic [2:0] stb_cnt_c;
   logic       multi_stb_c;
   assign stb_cnt_c   = 3'(mem_rd_stb) + 3'(mem_wr_stb) + 3'(io_rd_stb) + 3'(io_wr_stb);
   assign multi_stb_c = stb_cnt_c > 3'd1;

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   // next-state and datapath controls
   always_comb begin
      state_d     = state;
      load_pre    = 1'b0;
      clear_slots = 1'b0;
      apply_stb   = 1'b0;
      publish     = 1'b0;
      case (state)
         IDLE: begin
            if (insn_start) begin
               load_pre    = 1'b1;
               clear_slots = 1'b1;
               state_d     = OPEN;
            end
         end
         OPEN: begin
            // a restart without insn_done abandons the open record
            if (insn_start) begin
               load_pre    = 1'b1;
               clear_slots = 1'b1;
            end else begin
               apply_stb = 1'b1;
               if (insn_done) state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            publish = 1'b1;
            if (insn_start) begin
               load_pre    = 1'b1;
               clear_slots = 1'b1;
               state_d     = OPEN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // working record: pre-state capture and slot filling
   always_ff @(posedge clk) begin
      if (!reset) begin
         pre_q    <= '0;
         rd1_v    <= 1'b0;
         rd1_io   <= 1'b0;
         rd2_v    <= 1'b0;
         wr1_v    <= 1'b0;
         wr1_io   <= 1'b0;
         wr2_v    <= 1'b0;
         ovf_q    <= 1'b0;
         raddr1_q <= '0;
         raddr2_q <= '0;
         waddr1_q <= '0;
         waddr2_q <= '0;
         wdata1_q <= '0;
         wdata2_q <= '0;
      end else if (clear_slots) begin
         if (load_pre) pre_q <= regs_live;
         rd1_v    <= 1'b0;
         rd1_io   <= 1'b0;
         rd2_v    <= 1'b0;
         wr1_v    <= 1'b0;
         wr1_io   <= 1'b0;
         wr2_v    <= 1'b0;
         ovf_q    <= 1'b0;
         raddr1_q <= '0;
         raddr2_q <= '0;
         waddr1_q <= '0;
         waddr2_q <= '0;
         wdata1_q <= '0;
         wdata2_q <= '0;
      end else if (apply_stb) begin
         if (multi_stb_c) begin
            ovf_q <= 1'b1;
         end else if (mem_rd_stb && !bus_fetch) begin
            if (!rd1_v) begin
               rd1_v    <= 1'b1;
               raddr1_q <= bus_addr;
            end else if (!rd2_v) begin
               rd2_v    <= 1'b1;
               raddr2_q <= bus_addr;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (mem_wr_stb) begin
            if (!wr1_v) begin
               wr1_v    <= 1'b1;
               waddr1_q <= bus_addr;
               wdata1_q <= bus_data;
            end else if (!wr2_v) begin
               wr2_v    <= 1'b1;
               waddr2_q <= bus_addr;
               wdata2_q <= bus_data;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (io_rd_stb) begin
            if (!rd1_v) begin
               rd1_v    <= 1'b1;
               rd1_io   <= 1'b1;
               raddr1_q <= bus_addr;
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (io_wr_stb) begin
            if (!wr1_v) begin
               wr1_v    <= 1'b1;
               wr1_io   <= 1'b1;
               waddr1_q <= bus_addr;
               wdata1_q <= bus_data;
            end else begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   // published record: loads only in CAPTURE, holds otherwise
   always_ff @(posedge clk) begin
      if (!reset) begin
         z80fi_valid    <= 1'b0;
         z80fi_regs_in  <= '0;
         z80fi_regs_out <= '0;
         mem_rd         <= 1'b0;
         mem_rd2        <= 1'b0;
         mem_wr         <= 1'b0;
         mem_wr2        <= 1'b0;
         io_rd          <= 1'b0;
         io_wr          <= 1'b0;
         bus_raddr      <= '0;
         bus_raddr2     <= '0;
         bus_waddr      <= '0;
         bus_waddr2     <= '0;
         bus_wdata      <= '0;
         bus_wdata2     <= '0;
         overflow       <= 1'b0;
         insn_count     <= '0;
      end else begin
         z80fi_valid <= publish;
         if (publish) begin
            z80fi_regs_in  <= pre_q;
            z80fi_regs_out <= regs_live;
            mem_rd         <= rd1_v & ~rd1_io;
            io_rd          <= rd1_v & rd1_io;
            mem_rd2        <= rd2_v;
            mem_wr         <= wr1_v & ~wr1_io;
            io_wr          <= wr1_v & wr1_io;
            mem_wr2        <= wr2_v;
            bus_raddr      <= raddr1_q;
            bus_raddr2     <= raddr2_q;
            bus_waddr      <= waddr1_q;
            bus_waddr2     <= waddr2_q;
            bus_wdata      <= wdata1_q;
            bus_wdata2     <= wdata2_q;
            overflow       <= ovf_q;
            insn_count     <= insn_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_z80fi_insn_recorder.sv
// Directed bench for z80fi_insn_recorder (counter narrowed to 4 bits so the
// wrap case is reachable quickly).
module tb_z80fi_insn_recorder;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             insn_start, insn_done;
   logic [209:0]     regs_live;
   logic             mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb, bus_fetch;
   logic [15:0]      bus_addr;
   logic [7:0]       bus_data;
   logic             z80fi_valid;
   logic [209:0]     z80fi_regs_in, z80fi_regs_out;
   logic             mem_rd, mem_rd2, mem_wr, mem_wr2, io_rd, io_wr;
   logic [15:0]      bus_raddr, bus_raddr2, bus_waddr, bus_waddr2;
   logic [7:0]       bus_wdata, bus_wdata2;
   logic             overflow;
   logic [CNT_W-1:0] insn_count;

   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int v0;

   logic [209:0] ra, rb, rc, rx;

   z80fi_insn_recorder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .insn_start(insn_start), .insn_done(insn_done), .regs_live(regs_live),
      .mem_rd_stb(mem_rd_stb), .mem_wr_stb(mem_wr_stb),
      .io_rd_stb(io_rd_stb), .io_wr_stb(io_wr_stb), .bus_fetch(bus_fetch),
      .bus_addr(bus_addr), .bus_data(bus_data),
      .z80fi_valid(z80fi_valid), .z80fi_regs_in(z80fi_regs_in),
      .z80fi_regs_out(z80fi_regs_out),
      .mem_rd(mem_rd), .mem_rd2(mem_rd2), .mem_wr(mem_wr), .mem_wr2(mem_wr2),
      .io_rd(io_rd), .io_wr(io_wr),
      .bus_raddr(bus_raddr), .bus_raddr2(bus_raddr2),
      .bus_waddr(bus_waddr), .bus_waddr2(bus_waddr2),
      .bus_wdata(bus_wdata), .bus_wdata2(bus_wdata2),
      .overflow(overflow), .insn_count(insn_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (z80fi_valid) vcount++;

   task automatic chk(input string tag, input logic [209:0] got, input logic [209:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock of stimulus; outputs are stable #1 after the edge on return
   task automatic drv(input logic st, input logic dn, input logic rd, input logic wr,
                      input logic ird, input logic iwr, input logic fe,
                      input logic [15:0] a, input logic [7:0] d);
      insn_start = st;  insn_done  = dn;
      mem_rd_stb = rd;  mem_wr_stb = wr;
      io_rd_stb  = ird; io_wr_stb  = iwr;
      bus_fetch  = fe;  bus_addr   = a;   bus_data = d;
      @(posedge clk);
      #1;
      insn_start = 1'b0; insn_done = 1'b0;
      mem_rd_stb = 1'b0; mem_wr_stb = 1'b0;
      io_rd_stb  = 1'b0; io_wr_stb  = 1'b0;
      bus_fetch  = 1'b0;
   endtask

   task automatic idle1();
      drv(0, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
   endtask

   initial begin
      ra = {{26{8'hA5}}, 2'b10};
      rb = {{26{8'h3C}}, 2'b01};
      rc = {{26{8'h96}}, 2'b11};
      rx = {{26{8'hFF}}, 2'b00};
      regs_live = ra;
      reset = 1'b0;
      insn_start = 0; insn_done = 0; mem_rd_stb = 0; mem_wr_stb = 0;
      io_rd_stb = 0; io_wr_stb = 0; bus_fetch = 0; bus_addr = '0; bus_data = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_valid", z80fi_valid, 0);
      chk("rst_count", insn_count, 0);
      chk("rst_regs_in", z80fi_regs_in, 0);
      chk("rst_raddr", bus_raddr, 0);
      reset = 1'b1;

      // basic read + write, fetch read ignored, pre-state latched at start
      regs_live = ra;
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      regs_live = rx;
      drv(0, 0, 1, 0, 0, 0, 1, 16'hFFFF, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h1234, 8'h00);
      drv(0, 0, 0, 1, 0, 0, 0, 16'h5678, 8'hAB);
      v0 = vcount;
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      chk("t1_valid_n1", z80fi_valid, 0);
      regs_live = rb;
      idle1();
      chk("t1_valid", z80fi_valid, 1);
      chk("t1_mem_rd", mem_rd, 1);
      chk("t1_raddr", bus_raddr, 16'h1234);
      chk("t1_mem_rd2", mem_rd2, 0);
      chk("t1_raddr2", bus_raddr2, 0);
      chk("t1_mem_wr", mem_wr, 1);
      chk("t1_waddr", bus_waddr, 16'h5678);
      chk("t1_wdata", bus_wdata, 8'hAB);
      chk("t1_waddr2", bus_waddr2, 0);
      chk("t1_ovf", overflow, 0);
      chk("t1_count", insn_count, 1);
      chk("t1_regs_in", z80fi_regs_in, ra);
      chk("t1_regs_out", z80fi_regs_out, rb);
      idle1();
      chk("t1_valid_off", z80fi_valid, 0);
      chk("t1_hold_raddr", bus_raddr, 16'h1234);
      chk("t1_pulses", vcount - v0, 1);

      // OUTI: memory read then io write
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h8000, 8'h00);
      drv(0, 0, 0, 0, 0, 1, 0, 16'h10FE, 8'h55);
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      idle1();
      chk("outi_mem_rd", mem_rd, 1);
      chk("outi_raddr", bus_raddr, 16'h8000);
      chk("outi_io_wr", io_wr, 1);
      chk("outi_mem_wr", mem_wr, 0);
      chk("outi_waddr", bus_waddr, 16'h10FE);
      chk("outi_wdata", bus_wdata, 8'h55);
      chk("outi_ovf", overflow, 0);
      chk("outi_count", insn_count, 2);

      // three reads: third overflows
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h0001, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h0002, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h0003, 8'h00);
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      idle1();
      chk("rd3_raddr", bus_raddr, 16'h0001);
      chk("rd3_raddr2", bus_raddr2, 16'h0002);
      chk("rd3_mem_rd2", mem_rd2, 1);
      chk("rd3_ovf", overflow, 1);
      chk("rd3_count", insn_count, 3);

      // two strobes in one cycle: nothing recorded
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 1, 1, 0, 0, 0, 16'h4321, 8'h77);
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      idle1();
      chk("multi_ovf", overflow, 1);
      chk("multi_mem_rd", mem_rd, 0);
      chk("multi_mem_wr", mem_wr, 0);
      chk("multi_raddr", bus_raddr, 0);
      chk("multi_wdata", bus_wdata, 0);

      // back-to-back: start in the CAPTURE cycle
      regs_live = ra;
      v0 = vcount;
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 0, 1, 0, 0, 0, 16'h0100, 8'h11);
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      regs_live = rb;
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      chk("b2b_valid1", z80fi_valid, 1);
      chk("b2b_out1", z80fi_regs_out, rb);
      chk("b2b_wr1", mem_wr, 1);
      regs_live = rx;
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      chk("b2b_valid_gap", z80fi_valid, 0);
      regs_live = rc;
      idle1();
      chk("b2b_valid2", z80fi_valid, 1);
      chk("b2b_in2", z80fi_regs_in, rb);
      chk("b2b_out2", z80fi_regs_out, rc);
      chk("b2b_wr2", mem_wr, 0);
      chk("b2b_count", insn_count, 6);
      chk("b2b_pulses", vcount - v0, 2);

      // restart inside OPEN discards the record; io read after mem read overflows
      v0 = vcount;
      regs_live = ra;
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h2222, 8'h00);
      regs_live = rb;
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h3333, 8'h00);
      drv(0, 0, 0, 0, 1, 0, 0, 16'h00FE, 8'h00);
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      idle1();
      chk("restart_in", z80fi_regs_in, rb);
      chk("restart_raddr", bus_raddr, 16'h3333);
      chk("restart_io_rd", io_rd, 0);
      chk("restart_ovf", overflow, 1);
      chk("restart_pulses", vcount - v0, 1);
      chk("restart_count", insn_count, 7);

      // reset while OPEN: no publish afterwards, everything zero
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 0, 1, 0, 0, 0, 0, 16'h4444, 8'h00);
      v0 = vcount;
      reset = 1'b0;
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      reset = 1'b1;
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      idle1();
      idle1();
      chk("rst2_pulses", vcount - v0, 0);
      chk("rst2_count", insn_count, 0);
      chk("rst2_raddr", bus_raddr, 0);
      chk("rst2_mem_rd", mem_rd, 0);
      chk("rst2_ovf", overflow, 0);
      chk("rst2_regs_out", z80fi_regs_out, 0);

      // counter wrap at 2^CNT_W
      for (int i = 0; i < 15; i++) begin
         drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
         drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
         idle1();
      end
      chk("wrap_max", insn_count, 15);
      drv(1, 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      drv(0, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
      idle1();
      chk("wrap_valid", z80fi_valid, 1);
      chk("wrap_zero", insn_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/z80fi_insn_recorder.md
Z80FI_INSN_RECORDER -- requirements
Module: z80fi_insn_recorder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the published-instruction counter.
REQ-002 SHALL have clk, input, 1, the system clock; all state updates on its rising edge.
REQ-003 SHALL have reset, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have insn_start, input, 1, a one-cycle pulse in the first M1 cycle of an instruction.
REQ-005 SHALL have insn_done, input, 1, a one-cycle pulse in the last cycle of an instruction.
REQ-006 SHALL have regs_live, input, 210, the packed live core state, MSB first: A,F,B,C,D,E,H,L,A',F',B',C',D',E',H',L' (8 each), IX,IY,SP,IP (16 each), I,R (8 each), IFF1,IFF2 (1 each).
REQ-007 SHALL have mem_rd_stb, mem_wr_stb, io_rd_stb, io_wr_stb, inputs, 1 each, one-cycle bus-transaction strobes.
REQ-008 SHALL have bus_fetch, input, 1, which marks a mem_rd_stb as an opcode/operand fetch.
REQ-009 SHALL have bus_addr (16) and bus_data (8) as inputs, valid in any strobe cycle.
REQ-010 SHALL have z80fi_valid, output, 1, a one-cycle pulse marking a published record.
REQ-011 SHALL have z80fi_regs_in and z80fi_regs_out, outputs, 210 each, the pre- and post-instruction state.
REQ-012 SHALL have mem_rd, mem_rd2, mem_wr, mem_wr2, io_rd, io_wr, outputs, 1 each, the record flags.
REQ-013 SHALL have bus_raddr, bus_raddr2, bus_waddr, bus_waddr2 (16 each) and bus_wdata, bus_wdata2 (8 each) as outputs.
REQ-014 SHALL have overflow, output, 1, set when the record lost a transaction.
REQ-015 SHALL have insn_count, output, CNT_W, the count of published records.

Function
REQ-016 SHALL implement the states IDLE, OPEN and CAPTURE.
REQ-017 In IDLE, insn_start SHALL latch regs_live into the working pre-state, clear the working slots and overflow, and go to OPEN; strobes and insn_done SHALL be ignored.
REQ-018 In OPEN, a non-fetch mem_rd_stb SHALL fill rd slot 1 (raddr) if empty, else rd slot 2 (raddr2), else set overflow.
REQ-019 In OPEN, mem_wr_stb SHALL fill wr slot 1 (waddr/wdata) if empty, else wr slot 2, else set overflow.
REQ-020 In OPEN, io_rd_stb SHALL occupy rd slot 1 with io_rd=1, and io_wr_stb SHALL occupy wr slot 1 with io_wr=1; if slot 1 is already occupied, overflow SHALL be set and nothing recorded.
REQ-021 A mem_rd_stb with bus_fetch=1 SHALL never be recorded.
REQ-022 More than one strobe in one cycle SHALL record none of them and set overflow.
REQ-023 insn_done in OPEN SHALL apply that cycle's strobe first, then go to CAPTURE.
REQ-024 In CAPTURE (cycle N+1 after insn_done in N), regs_live SHALL be latched as the post-state; the output registers SHALL load the pre-state, post-state, slots and overflow; z80fi_valid SHALL be 1 in cycle N+2 only; insn_count SHALL increment modulo 2^CNT_W.
REQ-025 insn_start in CAPTURE SHALL also latch that same regs_live sample as the next pre-state, clear the working slots and go to OPEN, with no lost cycle; otherwise CAPTURE SHALL go to IDLE.
REQ-026 insn_start in OPEN without a prior insn_done SHALL discard the open record, recapture the pre-state, clear the slots and stay in OPEN, with no valid pulse.
REQ-027 Record outputs SHALL change only on a publish and hold until the next publish.
REQ-028 Unused slot address and data outputs in a published record SHALL be 0.

Reset
REQ-029 With reset=0 at a clock edge, the state SHALL go to IDLE and every output (valid, flags, addresses, data, regs, overflow, insn_count) SHALL be 0.
REQ-030 Reset SHALL discard any open or capturing record without a publish, and SHALL take priority over all other inputs.

Verification
REQ-031 insn_start; mem_rd_stb (fetch=0, addr 0x1234); mem_wr_stb (addr 0x5678, data 0xAB); insn_done -> two cycles later valid=1 once, mem_rd=1, raddr=0x1234, mem_wr=1, waddr=0x5678, wdata=0xAB, insn_count=1.
REQ-032 OUTI sequence (non-fetch read 0x8000, io_wr addr 0x10FE data 0x55) -> mem_rd=1, raddr=0x8000, io_wr=1, waddr=0x10FE, wdata=0x55, overflow=0.
REQ-033 Three non-fetch reads at 0x0001, 0x0002, 0x0003 -> raddr=0x0001, raddr2=0x0002, overflow=1.
REQ-034 Back-to-back instructions with insn_start in the CAPTURE cycle -> record 2's regs_in equals record 1's regs_out, and both valid pulses occur.
REQ-035 Reset asserted in OPEN, then released, then insn_done -> no valid pulse and all outputs 0.
REQ-036 insn_count preset to 2^CNT_W-1 by publishing, then one more record -> insn_count wraps to 0.
